// File: rtl/eth_phy_10g_serdes_model_if.sv
// Bundles the serdes model's PHY-facing signals: the transmit block and the
// slip request go into the model, and the realigned block and counters come back out.
interface eth_phy_10g_serdes_model_if;
    logic [63:0] tx_data;
    logic [1:0]  tx_hdr;
    logic        bitslip;
    logic [15:0] cfg_err_period;
    logic [63:0] rx_data;
    logic [1:0]  rx_hdr;
    logic [15:0] slip_count;
    logic [15:0] err_count;

    // PHY side: drives the transmit block and bitslip, and reads back the realigned block.
    modport master (
        output tx_data, tx_hdr, bitslip, cfg_err_period,
        input  rx_data, rx_hdr, slip_count, err_count
    );

    // Model side.
    modport slave (
        input  tx_data, tx_hdr, bitslip, cfg_err_period,
        output rx_data, rx_hdr, slip_count, err_count
    );
endinterface

// File: rtl/eth_phy_10g_serdes_model.sv
// Loopback serdes model for a 10G PCS. Each transmitted 66-bit block is
// realigned through a bit window with a slip-controlled offset. The model can
// also corrupt the sync header of every Nth block.
module eth_phy_10g_serdes_model #(
    parameter int         INIT_OFFSET = 0,
    parameter logic [1:0] ERR_HDR     = 2'b11
) (
    input logic                         clk,
    input logic                         rst,
    eth_phy_10g_serdes_model_if.slave   bus
);

    // Serial order on the wire: hdr[0] first, then data LSB-first.
    logic [65:0]  tx_block;
    logic [65:0]  prev_block;
    logic [131:0] window;
    logic [65:0]  sel;
    logic [6:0]   offset;
    logic         bitslip_q;
    logic         slip_edge;
    logic [15:0]  blk_cnt;
    logic         inject;
    logic [63:0]  rx_data_q;
    logic [1:0]   rx_hdr_q;
    logic [15:0]  slip_count_q;
    logic [15:0]  err_count_q;

    assign tx_block  = {bus.tx_data, bus.tx_hdr};

    // The older block sits in the low half, so offset 0 reproduces the input
    // unchanged. A non-zero offset pulls leading bits of the newer block into the output.
    assign window    = {tx_block, prev_block};
    assign sel       = 66'(window >> offset);

    assign slip_edge = bus.bitslip & ~bitslip_q;

    // The compare uses >= rather than ==, so lowering the period below the
    // running count makes the very next block take the injection.
    assign inject    = (bus.cfg_err_period != 16'd0) &&
                       (blk_cnt >= bus.cfg_err_period - 16'd1);

    // Capture the incoming block, then register the realigned selection with optional header corruption.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_block <= '0;
            rx_data_q  <= '0;
            rx_hdr_q   <= 2'b00;
        end else begin
            prev_block <= tx_block;
            rx_data_q  <= sel[65:2];
            rx_hdr_q   <= inject ? ERR_HDR : sel[1:0];
        end
    end

    // Detect bitslip rising edges and advance the window offset modulo 66.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitslip_q    <= 1'b0;
            offset       <= 7'(INIT_OFFSET);
            slip_count_q <= '0;
        end else begin
            bitslip_q <= bus.bitslip;
            if (slip_edge) begin
                offset <= (offset == 7'd65) ? 7'd0 : offset + 7'd1;
                if (slip_count_q != 16'hFFFF) begin
                    slip_count_q <= slip_count_q + 16'd1;
                end
            end
        end
    end

    // Block counter that paces header injection, plus a saturating count of injected blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt     <= '0;
            err_count_q <= '0;
        end else begin
            if (bus.cfg_err_period == 16'd0) begin
                blk_cnt <= '0;
            end else if (inject) begin
                blk_cnt <= '0;
            end else begin
                blk_cnt <= blk_cnt + 16'd1;
            end
            if (inject && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_hdr     = rx_hdr_q;
    assign bus.slip_count = slip_count_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_eth_phy_10g_serdes_model.sv
// Self-checking bench for eth_phy_10g_serdes_model. The reference treats the
// input as one long serial bit stream. Each output block is the 66-bit slice of
// that stream that starts one block back, shifted by the number of slips seen so far.
module tb_eth_phy_10g_serdes_model;

    localparam int         INIT = 0;
    localparam logic [1:0] ERR  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    eth_phy_10g_serdes_model_if bus ();

    eth_phy_10g_serdes_model #(
        .INIT_OFFSET (INIT),
        .ERR_HDR     (ERR)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;

    // Reference state: every block presented since reset, the current slip
    // offset, the counters, and the injection pacing.
    logic [65:0] hist[$];
    int          k;
    int          off;
    int          slips;
    int          errs;
    int          cnt;
    bit          prev_bs;
    logic [15:0] period = 16'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 66 bits of the serial stream, starting at block k-1 plus the slip offset.
    // Bits before the first block after reset read as zero.
    function automatic logic [65:0] stream_slice(input int blk, input int shift);
        logic [65:0] r;
        logic [65:0] b;
        int          pos;
        r = '0;
        for (int i = 0; i < 66; i++) begin
            pos = 66 * (blk - 1) + shift + i;
            if (pos >= 0) begin
                b    = hist[pos / 66];
                r[i] = b[pos % 66];
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        k       = 0;
        off     = INIT;
        slips   = 0;
        errs    = 0;
        cnt     = 0;
        prev_bs = 1'b0;
    endtask

    // Entered just after a falling edge. Raises rst between clock edges, checks
    // that the outputs clear without waiting for a clock, then releases on a falling edge.
    task automatic do_reset(input int cycles, input bit bs);
        bus.bitslip = bs;
        #2 rst = 1'b1;
        #1;
        check("rst_rx_data", bus.rx_data, 64'd0);
        check("rst_rx_hdr", 64'(bus.rx_hdr), 64'd0);
        check("rst_slip_count", 64'(bus.slip_count), 64'd0);
        check("rst_err_count", 64'(bus.err_count), 64'd0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle. Drives inputs on the falling edge, advances the model at
    // the rising edge, and compares 1 ns later.
    task automatic step(input logic [63:0] d, input logic [1:0] h, input bit bs);
        logic [65:0] e;
        logic [1:0]  eh;
        bit          inj;
        bus.tx_data        = d;
        bus.tx_hdr         = h;
        bus.bitslip        = bs;
        bus.cfg_err_period = period;
        @(posedge clk);
        hist.push_back({d, h});
        e   = stream_slice(k, off);
        inj = 1'b0;
        if (period == 16'd0) begin
            cnt = 0;
        end else if (cnt >= int'(period) - 1) begin
            inj = 1'b1;
            cnt = 0;
        end else begin
            cnt++;
        end
        eh = inj ? ERR : e[1:0];
        if (inj && errs < 65535) errs++;
        if (bs && !prev_bs) begin
            off = (off + 1) % 66;
            if (slips < 65535) slips++;
        end
        prev_bs = bs;
        k++;
        #1;
        check("rx_data", bus.rx_data, e[65:2]);
        check("rx_hdr", 64'(bus.rx_hdr), 64'(eh));
        check("slip_count", 64'(bus.slip_count), 64'(slips));
        check("err_count", 64'(bus.err_count), 64'(errs));
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        int          inj_at[$];
        logic [63:0] d;
        int          s0;
        bit          bs;

        bus.tx_data        = '0;
        bus.tx_hdr         = 2'b00;
        bus.bitslip        = 1'b0;
        bus.cfg_err_period = '0;
        model_reset();
        @(negedge clk);
        do_reset(2, 1'b0);

        // Constant idle pattern at offset 0 passes through unchanged.
        for (int i = 0; i < 10; i++) step(64'h0707070707070707, 2'b01, 1'b0);
        check("idle_data", bus.rx_data, 64'h0707070707070707);
        check("idle_hdr", 64'(bus.rx_hdr), 64'd1);
        check("idle_slips", 64'(bus.slip_count), 64'd0);

        // Alternating payload with a single slip pulse.
        for (int i = 0; i < 24; i++) begin
            d = i[0] ? 64'hAAAAAAAAAAAAAAAA : 64'h5555555555555555;
            step(d, 2'b10, i == 6);
        end
        check("one_slip", 64'(bus.slip_count), 64'd1);

        // 65 more pulses bring the offset back around to where it started.
        for (int p = 0; p < 65; p++) begin
            step(rnd64(), 2'($urandom()), 1'b1);
            for (int j = 0; j < 8; j++) step(rnd64(), 2'($urandom()), 1'b0);
        end
        check("wrap_slips", 64'(bus.slip_count), 64'd66);
        check("wrap_delay_data", bus.rx_data, hist[hist.size() - 2][65:2]);
        check("wrap_delay_hdr", 64'(bus.rx_hdr), 64'(hist[hist.size() - 2][1:0]));

        // A bitslip held high for 20 cycles counts once.
        s0 = slips;
        for (int i = 0; i < 20; i++) step(rnd64(), 2'b01, 1'b1);
        step(rnd64(), 2'b01, 1'b0);
        check("held_slip", 64'(bus.slip_count), 64'(s0 + 1));

        // Reset mid-stream with bitslip high: the stored block is discarded,
        // and the level that was already high counts as an edge.
        do_reset(3, 1'b1);
        step(rnd64(), 2'b01, 1'b1);
        check("post_rst_first", bus.rx_data, 64'd0);
        check("post_rst_slip", 64'(bus.slip_count), 64'd1);
        step(rnd64(), 2'b01, 1'b1);
        check("post_rst_slip_hold", 64'(bus.slip_count), 64'd1);
        do_reset(1, 1'b0);

        // Period 10 over 100 blocks: 10 corrupted headers, evenly spaced.
        period = 16'd10;
        for (int i = 0; i < 100; i++) begin
            step(rnd64(), 2'b01, 1'b0);
            if (bus.rx_hdr == 2'b11) inj_at.push_back(i);
        end
        check("inj_count", 64'(inj_at.size()), 64'd10);
        check("inj_errcnt", 64'(bus.err_count), 64'd10);
        for (int i = 1; i < inj_at.size(); i++) begin
            check("inj_spacing", 64'(inj_at[i] - inj_at[i - 1]), 64'd10);
        end

        // Period 1 injects on every block; lowering the period mid-count
        // injects immediately; period 0 stops injection.
        period = 16'd1;
        for (int i = 0; i < 5; i++) step(rnd64(), 2'b01, 1'b0);
        check("p1_hdr", 64'(bus.rx_hdr), 64'(ERR));
        period = 16'd10;
        for (int i = 0; i < 7; i++) step(rnd64(), 2'b01, 1'b0);
        period = 16'd3;
        step(rnd64(), 2'b01, 1'b0);
        check("lowered_inject", 64'(bus.rx_hdr), 64'(ERR));
        period = 16'd0;
        for (int i = 0; i < 5; i++) step(rnd64(), 2'b01, 1'b0);

        // Random traffic: slips, periods and payloads drawn at random, so
        // slips and injections sometimes land in the same cycle.
        for (int i = 0; i < 300; i++) begin
            if (i % 40 == 0) begin
                case ($urandom_range(0, 3))
                    0:       period = 16'd0;
                    1:       period = 16'd1;
                    2:       period = 16'd3;
                    default: period = 16'd7;
                endcase
            end
            bs = ($urandom_range(0, 3) == 0);
            step(rnd64(), 2'($urandom()), bs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
